// File: rtl/hbridge_gate_driver.sv
// H-bridge gate driver: three-level command to four gates with per-leg deadtime and sticky invalid-code fault.
// Optional build macro ZERO_ALTERNATE_EN alternates the zero command between zero-low and zero-high.
module hbridge_gate_driver #(
  parameter int DEADTIME = 10,
  parameter int DT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] v_in,
  output logic [3:0] s,
  output logic       fault,
  output logic       busy
);

  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_HI  = 2'd1;
  localparam logic [1:0] ST_LO  = 2'd2;
  localparam logic [1:0] ST_DT  = 2'd3;

  localparam logic [1:0] V_POS  = 2'b01;
  localparam logic [1:0] V_ZERO = 2'b00;
  localparam logic [1:0] V_NEG  = 2'b11;
  localparam logic [1:0] V_BAD  = 2'b10;

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

  logic [1:0] r_v_q;
  logic       r_fault;
  logic       r_busy;
  logic [3:0] r_s;
  logic       w_force_off;
  logic       w_zero_hi;
  logic [1:0] w_tgt_hi;
  logic [1:0] w_hi_next;
  logic [1:0] w_lo_next;
  logic [1:0] w_dt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v_q <= V_ZERO;
    end else begin
      r_v_q <= v_in;
    end
  end

`ifdef ZERO_ALTERNATE_EN
  logic r_toggle;
  logic r_zero_hi;
  logic w_enter_zero;

  assign w_enter_zero = (v_in == V_ZERO) && ((r_v_q == V_POS) || (r_v_q == V_NEG));

  // r_zero_hi is the phase of the zero currently held; r_toggle is the phase the next zero will use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_toggle  <= 1'b0;
      r_zero_hi <= 1'b0;
    end else if (w_enter_zero) begin
      r_zero_hi <= r_toggle;
      r_toggle  <= ~r_toggle;
    end
  end

  assign w_zero_hi = r_zero_hi;
`else
  assign w_zero_hi = 1'b0;
`endif

  always_comb begin
    w_tgt_hi = 2'b00;
    case (r_v_q)
      V_POS:   w_tgt_hi = 2'b01;
      V_NEG:   w_tgt_hi = 2'b10;
      V_ZERO:  w_tgt_hi = {w_zero_hi, w_zero_hi};
      default: w_tgt_hi = 2'b00;
    endcase
  end

  // An invalid code drops the legs on the same edge the fault flag is raised.
  assign w_force_off = !en || r_fault || (r_v_q == V_BAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
    end else if (!en) begin
      r_fault <= 1'b0;
    end else if (r_v_q == V_BAD) begin
      r_fault <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_leg
      logic [1:0]      r_state;
      logic [1:0]      w_state_next;
      logic            r_tgt;
      logic            w_tgt_next;
      logic [DT_W-1:0] r_cnt;
      logic [DT_W-1:0] w_cnt_next;

      always_comb begin
        w_state_next = r_state;
        w_tgt_next   = r_tgt;
        w_cnt_next   = r_cnt;
        if (w_force_off) begin
          w_state_next = ST_OFF;
        end else begin
          case (r_state)
            ST_OFF: begin
              w_state_next = ST_DT;
              w_tgt_next   = w_tgt_hi[gi];
              w_cnt_next   = DT_LOAD;
            end
            ST_HI: begin
              if (!w_tgt_hi[gi]) begin
                w_state_next = ST_DT;
                w_tgt_next   = 1'b0;
                w_cnt_next   = DT_LOAD;
              end
            end
            ST_LO: begin
              if (w_tgt_hi[gi]) begin
                w_state_next = ST_DT;
                w_tgt_next   = 1'b1;
                w_cnt_next   = DT_LOAD;
              end
            end
            default: begin
              if (w_tgt_hi[gi] != r_tgt) begin
                w_tgt_next = w_tgt_hi[gi];
                w_cnt_next = DT_LOAD;
              end else if (r_cnt == '0) begin
                w_state_next = r_tgt ? ST_HI : ST_LO;
              end else begin
                w_cnt_next = r_cnt - DT_W'(1);
              end
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= ST_OFF;
          r_tgt   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_tgt   <= w_tgt_next;
          r_cnt   <= w_cnt_next;
        end
      end

      assign w_hi_next[gi] = (w_state_next == ST_HI);
      assign w_lo_next[gi] = (w_state_next == ST_LO);
      assign w_dt_next[gi] = (w_state_next == ST_DT);
    end
  endgenerate

  // Gates are flops loaded from the next leg states, so they track the states without decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s    <= 4'b0000;
      r_busy <= 1'b0;
    end else begin
      r_s    <= {w_lo_next[1], w_hi_next[1], w_lo_next[0], w_hi_next[0]};
      r_busy <= |w_dt_next;
    end
  end

  assign s     = r_s;
  assign busy  = r_busy;
  assign fault = r_fault;

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Directed table-driven bench for hbridge_gate_driver (DEADTIME=10); each record drives en/v_in,
// advances a number of clock edges and checks s/fault/busy.
module tb_hbridge_gate_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] v_in = 2'b00;
  logic [3:0] s;
  logic       fault;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       en;
    logic [1:0] v;
    int         cyc;
    logic [3:0] s;
    logic       f;
    logic       b;
    string      name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  hbridge_gate_driver #(.DEADTIME(10), .DT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .v_in  (v_in),
    .s     (s),
    .fault (fault),
    .busy  (busy)
  );

  function automatic void add(input logic e, input logic [1:0] v, input int c,
                              input logic [3:0] es, input logic ef, input logic eb,
                              input string nm);
    vec_t t;
    t.en = e; t.v = v; t.cyc = c; t.s = es; t.f = ef; t.b = eb; t.name = nm;
    vecs.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [3:0] es, input logic ef, input logic eb);
    n_checks++;
    if (s === es && fault === ef && busy === eb) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got s=%b fault=%b busy=%b, want s=%b fault=%b busy=%b",
               nm, s, fault, busy, es, ef, eb);
    end
  endtask

  // Shoot-through guard on every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      n_checks++;
      if ((s[0] & s[1]) | (s[2] & s[3])) begin
        $display("FAIL shoot_through: s=%b at %0t, want no leg with both switches on", s, $time);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    // Start-up: v_q loads +1 while disabled, then enable.
    add(1'b0, 2'b01, 2,  4'b0000, 1'b0, 1'b0, "idle_disabled");
    add(1'b1, 2'b01, 1,  4'b0000, 1'b0, 1'b1, "en_first_dt");
    add(1'b1, 2'b01, 9,  4'b0000, 1'b0, 1'b1, "en_dt_last");
    add(1'b1, 2'b01, 1,  4'b1001, 1'b0, 1'b0, "en_pos_on");
    add(1'b1, 2'b01, 5,  4'b1001, 1'b0, 1'b0, "pos_steady");
`ifdef ZERO_ALTERNATE_EN
    add(1'b1, 2'b00, 2,  4'b1000, 1'b0, 1'b1, "alt_zero1_dt");
    add(1'b1, 2'b00, 10, 4'b1010, 1'b0, 1'b0, "alt_zero_low");
    add(1'b1, 2'b11, 2,  4'b0010, 1'b0, 1'b1, "alt_neg_dt");
    add(1'b1, 2'b11, 10, 4'b0110, 1'b0, 1'b0, "alt_neg_on");
    add(1'b1, 2'b00, 2,  4'b0100, 1'b0, 1'b1, "alt_zero2_dt");
    add(1'b1, 2'b00, 10, 4'b0101, 1'b0, 1'b0, "alt_zero_high");
`else
    // +1 -> 0: leg A off one edge after v_q, on again DEADTIME edges later; B low untouched.
    add(1'b1, 2'b00, 1,  4'b1001, 1'b0, 1'b0, "zero_vq_edge");
    add(1'b1, 2'b00, 1,  4'b1000, 1'b0, 1'b1, "zero_a_off");
    add(1'b1, 2'b00, 9,  4'b1000, 1'b0, 1'b1, "zero_dt_last");
    add(1'b1, 2'b00, 1,  4'b1010, 1'b0, 1'b0, "zero_on");
    add(1'b1, 2'b11, 1,  4'b1010, 1'b0, 1'b0, "neg_vq_edge");
    add(1'b1, 2'b11, 1,  4'b0010, 1'b0, 1'b1, "neg_b_off");
    add(1'b1, 2'b11, 9,  4'b0010, 1'b0, 1'b1, "neg_dt_last");
    add(1'b1, 2'b11, 1,  4'b0110, 1'b0, 1'b0, "neg_on");
    add(1'b1, 2'b00, 2,  4'b0010, 1'b0, 1'b1, "negzero_dt");
    add(1'b1, 2'b00, 10, 4'b1010, 1'b0, 1'b0, "negzero_on");
    add(1'b1, 2'b01, 2,  4'b1000, 1'b0, 1'b1, "zeropos_dt");
    add(1'b1, 2'b01, 10, 4'b1001, 1'b0, 1'b0, "zeropos_on");
    // +1 -> 0, reversed back to +1 after 4 deadtime cycles: deadtime restarts.
    add(1'b1, 2'b00, 2,  4'b1000, 1'b0, 1'b1, "rev_dt_start");
    add(1'b1, 2'b00, 3,  4'b1000, 1'b0, 1'b1, "rev_dt_4cyc");
    add(1'b1, 2'b01, 1,  4'b1000, 1'b0, 1'b1, "rev_vq_edge");
    add(1'b1, 2'b01, 1,  4'b1000, 1'b0, 1'b1, "rev_reload");
    add(1'b1, 2'b01, 9,  4'b1000, 1'b0, 1'b1, "rev_dt_last");
    add(1'b1, 2'b01, 1,  4'b1001, 1'b0, 1'b0, "rev_pos_on");
    // Invalid code: fault and gates off two edges later, sticky until en=0.
    add(1'b1, 2'b10, 1,  4'b1001, 1'b0, 1'b0, "bad_vq_edge");
    add(1'b1, 2'b10, 1,  4'b0000, 1'b1, 1'b0, "bad_fault");
    add(1'b1, 2'b01, 5,  4'b0000, 1'b1, 1'b0, "fault_sticky");
    add(1'b0, 2'b01, 1,  4'b0000, 1'b0, 1'b0, "fault_clear");
    add(1'b1, 2'b01, 1,  4'b0000, 1'b0, 1'b1, "reen_dt");
    add(1'b1, 2'b01, 9,  4'b0000, 1'b0, 1'b1, "reen_dt_last");
    add(1'b1, 2'b01, 1,  4'b1001, 1'b0, 1'b0, "reen_on");
    // en falls mid-deadtime: counter discarded, full deadtime on re-enable.
    add(1'b1, 2'b00, 3,  4'b1000, 1'b0, 1'b1, "middt_busy");
    add(1'b0, 2'b00, 1,  4'b0000, 1'b0, 1'b0, "middt_en_low");
    add(1'b1, 2'b00, 1,  4'b0000, 1'b0, 1'b1, "middt_reen");
    add(1'b1, 2'b00, 9,  4'b0000, 1'b0, 1'b1, "middt_dt_last");
    add(1'b1, 2'b00, 1,  4'b1010, 1'b0, 1'b0, "middt_zero_on");
    add(1'b0, 2'b10, 3,  4'b0000, 1'b0, 1'b0, "bad_while_off");
    add(1'b0, 2'b00, 1,  4'b0000, 1'b0, 1'b0, "off_quiet");
    // en and a new command arrive together: B settles on the old target, A restarts.
    add(1'b1, 2'b01, 11, 4'b1000, 1'b0, 1'b1, "joint_b_on");
    add(1'b1, 2'b01, 1,  4'b1001, 1'b0, 1'b0, "joint_a_on");
`endif

    rst = 1'b0; en = 1'b1; v_in = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 1'b0, 1'b0);
    $display("[reset] s=%b fault=%b busy=%b", s, fault, busy);
    en = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en   = vecs[i].en;
      v_in = vecs[i].v;
      repeat (vecs[i].cyc) @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].s, vecs[i].f, vecs[i].b);
      $display("[%0d] %s en=%b v=%b +%0d: s=%b fault=%b busy=%b", i, vecs[i].name,
               vecs[i].en, vecs[i].v, vecs[i].cyc, s, fault, busy);
    end

    // Asynchronous reset: gates drop before the next clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 4'b0000, 1'b0, 1'b0);
    $display("[async] s=%b fault=%b busy=%b", s, fault, busy);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
